serial_adder: RTL and testbench

Parametrised multi-cycle adder that computes `sum = a + b + ci` over WIDTH bits, processing DIGIT bits per clock through one DIGIT-wide full-adder slice and a registered carry. It is the sequential successor to the single-bit full adder. It is the area-minimal adder for datapaths that can tolerate WIDTH/DIGIT cycles of latency. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The master side drives the operands and accepts the results; the slave side is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: sum = a + b + ci over WIDTH bits, DIGIT bits per clock, through one
// DIGIT-wide adder slice with a registered carry between steps.
module serial_adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, psum, psum_nxt, sum_q;
  logic             carry, co_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic             last;

  serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a   (a_sh[DIGIT-1:0]),
    .b   (b_sh[DIGIT-1:0]),
    .cin (carry),
    .s   (dsum),
    .cout(dcarry)
  );

  // New digit enters at the top; after STEPS shifts the LSB digit lands at bit 0.
  assign psum_nxt = WIDTH'({dsum, psum} >> DIGIT);
  assign last     = (cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sh  <= bus.a;
          b_sh  <= bus.b;
          carry <= bus.ci;
          cnt   <= '0;
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          psum  <= psum_nxt;
          carry <= dcarry;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum_q <= psum_nxt;
            co_q  <= dcarry;
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready deliberately looks only at state and rst, never at the handshake inputs.
  assign bus.in_ready  = !rst && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios on WIDTH=8 DIGIT=1/4 plus randomized
// traffic on six WIDTH/DIGIT configurations checked against plain a+b+ci arithmetic.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   rand_go  = 1'b0;
  int   rand_done = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) u1 ();
  serial_adder_if #(.WIDTH(8)) u4 ();
  serial_adder #(.WIDTH(8), .DIGIT(1)) dut_d1 (.clk(clk), .rst(rst), .bus(u1.slave));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut_d4 (.clk(clk), .rst(rst), .bus(u4.slave));

  for (genvar g = 0; g < 6; g++) begin : g_rand
    localparam int W = (g < 3) ? 8 : 16;
    localparam int D = 1 << (g % 3);
    serial_adder_if #(.WIDTH(W)) rb ();
    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst(rst), .bus(rb.slave));

    initial begin : run
      logic [W:0] expq[$];
      logic [W:0] e;
      int sent, got;
      bit acc;
      rb.in_valid = 1'b0; rb.a = '0; rb.b = '0; rb.ci = 1'b0; rb.out_ready = 1'b0;
      sent = 0; got = 0; acc = 1'b0;
      wait (rand_go);
      for (int k = 0; k < 20000 && got < 200; k++) begin
        @(negedge clk);
        rb.out_ready = ($urandom_range(0, 3) != 0);
        if (rb.out_valid && rb.out_ready) begin
          n_checks++;
          if (expq.size() == 0) begin
            n_fails++;
            $display("FAIL rand_w%0d_d%0d unexpected result %h, required none", W, D, {rb.co, rb.sum});
          end else begin
            e = expq.pop_front();
            if ({rb.co, rb.sum} !== e) begin
              n_fails++;
              $display("FAIL rand_w%0d_d%0d result %h, required %h", W, D, {rb.co, rb.sum}, e);
            end
          end
          got++;
        end
        if (acc) begin acc = 1'b0; rb.in_valid = 1'b0; end
        if (!rb.in_valid && sent < 200 && $urandom_range(0, 2) != 0) begin
          rb.a = W'($urandom); rb.b = W'($urandom); rb.ci = 1'($urandom);
          rb.in_valid = 1'b1;
        end
        if (rb.in_valid && rb.in_ready) begin
          expq.push_back((W+1)'(rb.a) + (W+1)'(rb.b) + (W+1)'(rb.ci));
          sent++;
          acc = 1'b1;
        end
      end
      n_checks++;
      if (got != 200) begin
        n_fails++;
        $display("FAIL rand_w%0d_d%0d_count results %0d, required 200", W, D, got);
      end
      rand_done++;
    end
  end

  task automatic start_u1(input logic [7:0] xa, input logic [7:0] xb, input logic xci);
    @(negedge clk);
    u1.a = xa; u1.b = xb; u1.ci = xci; u1.in_valid = 1'b1;
    @(posedge clk); #1;
    u1.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({u1.in_ready, u1.out_valid, u1.co, u1.sum} !== 11'h0) begin
      n_fails++;
      $display("FAIL reset_state rdy/vld/co/sum %h, required 000", {u1.in_ready, u1.out_valid, u1.co, u1.sum});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if (u1.in_ready !== 1'b1 || u1.out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release in_ready %b out_valid %b, required 1 0", u1.in_ready, u1.out_valid);
    end
  endtask

  task automatic test_d1_basic;
    logic [7:0] ta[2] = '{8'hFF, 8'h12};
    logic [7:0] tb_[2] = '{8'h01, 8'h34};
    logic       tc[2] = '{1'b0, 1'b1};
    logic [8:0] te[2] = '{9'h100, 9'h047};
    for (int i = 0; i < 2; i++) begin
      u1.out_ready = 1'b0;
      start_u1(ta[i], tb_[i], tc[i]);
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); #1;
        n_checks++;
        if (u1.out_valid !== 1'(k == 8)) begin
          n_fails++;
          $display("FAIL d1_latency op%0d edge%0d out_valid %b, required %b", i, k, u1.out_valid, k == 8);
        end
      end
      n_checks++;
      if ({u1.co, u1.sum} !== te[i]) begin
        n_fails++;
        $display("FAIL d1_result op%0d got %h, required %h", i, {u1.co, u1.sum}, te[i]);
      end
      u1.out_ready = 1'b1;
      @(posedge clk); #1;
      u1.out_ready = 1'b0;
      n_checks++;
      if (u1.out_valid !== 1'b0 || u1.in_ready !== 1'b1 || {u1.co, u1.sum} !== te[i]) begin
        n_fails++;
        $display("FAIL d1_drain op%0d vld %b rdy %b res %h, required 0 1 %h", i, u1.out_valid, u1.in_ready, {u1.co, u1.sum}, te[i]);
      end
    end
  endtask

  task automatic test_digit4;
    u4.out_ready = 1'b0;
    @(negedge clk);
    u4.a = 8'hF0; u4.b = 8'h0F; u4.ci = 1'b1; u4.in_valid = 1'b1;
    @(posedge clk); #1;
    u4.in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      n_checks++;
      if (u4.in_ready !== 1'b0 || u4.out_valid !== 1'b0) begin
        n_fails++;
        $display("FAIL d4_run cycle%0d in_ready %b out_valid %b, required 0 0", k, u4.in_ready, u4.out_valid);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (u4.out_valid !== 1'b1 || {u4.co, u4.sum} !== 9'h100 || u4.in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL d4_result vld %b res %h rdy %b, required 1 100 0", u4.out_valid, {u4.co, u4.sum}, u4.in_ready);
    end
    u4.out_ready = 1'b1;
    @(posedge clk); #1;
    u4.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    u1.out_ready = 1'b0;
    start_u1(8'h3C, 8'h81, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      u1.in_valid = (k % 3 == 0);
      u1.a = 8'hAA; u1.b = 8'h55; u1.ci = 1'b1;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (u1.out_valid !== 1'b1 || {u1.co, u1.sum} !== 9'h0BE || u1.in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL stall cycle%0d vld %b res %h rdy %b, required 1 0be 0", k, u1.out_valid, {u1.co, u1.sum}, u1.in_ready);
      end
      u1.in_valid = (k % 2 == 0);
      @(posedge clk); #1;
    end
    u1.in_valid = 1'b0;
    u1.out_ready = 1'b1;
    @(posedge clk); #1;
    u1.out_ready = 1'b0;
    n_checks++;
    if (u1.out_valid !== 1'b0 || {u1.co, u1.sum} !== 9'h0BE) begin
      n_fails++;
      $display("FAIL stall_release vld %b res %h, required 0 0be", u1.out_valid, {u1.co, u1.sum});
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    u1.out_ready = 1'b1;
    start_u1(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; #1;
    n_checks++;
    if ({u1.out_valid, u1.co, u1.sum, u1.in_ready} !== 11'h0) begin
      n_fails++;
      $display("FAIL midrst_state vld %b co %b sum %h rdy %b, required 0 0 00 0", u1.out_valid, u1.co, u1.sum, u1.in_ready);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (u1.out_valid) seen = 1'b1; end
    n_checks++;
    if (seen) begin
      n_fails++;
      $display("FAIL midrst_ghost out_valid pulse seen 1, required 0");
    end
    u1.out_ready = 1'b0;
    start_u1(8'h80, 8'h80, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (u1.out_valid !== 1'b1 || {u1.co, u1.sum} !== 9'h100) begin
      n_fails++;
      $display("FAIL midrst_fresh vld %b res %h, required 1 100", u1.out_valid, {u1.co, u1.sum});
    end
    u1.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [8:0] expq[$];
    logic [8:0] e;
    int  acc[$];
    bit  prev_ov, pend;
    int  nres;
    prev_ov = 1'b0; pend = 1'b0; nres = 0;
    u1.out_ready = 1'b1;
    u1.a = 8'($urandom); u1.b = 8'($urandom); u1.ci = 1'($urandom);
    u1.in_valid = 1'b1;
    for (int k = 0; k < 60 && nres < 3; k++) begin
      @(negedge clk);
      if (u1.out_valid) begin
        n_checks++;
        e = (expq.size() != 0) ? expq.pop_front() : 9'h1FF;
        if (prev_ov || {u1.co, u1.sum} !== e) begin
          n_fails++;
          $display("FAIL b2b_result res %h prev_vld %b, required %h 0", {u1.co, u1.sum}, prev_ov, e);
        end
        nres++;
      end
      prev_ov = u1.out_valid;
      if (u1.in_valid && u1.in_ready) begin
        acc.push_back(k);
        expq.push_back(9'(u1.a) + 9'(u1.b) + 9'(u1.ci));
        pend = 1'b1;
      end
      @(posedge clk); #1;
      if (pend) begin
        pend = 1'b0;
        if (acc.size() == 3) u1.in_valid = 1'b0;
        else begin u1.a = 8'($urandom); u1.b = 8'($urandom); u1.ci = 1'($urandom); end
      end
    end
    u1.in_valid = 1'b0;
    n_checks++;
    if (nres != 3 || acc.size() != 3) begin
      n_fails++;
      $display("FAIL b2b_count results %0d accepts %0d, required 3 3", nres, acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (acc[i] - acc[i-1] != 10) begin
          n_fails++;
          $display("FAIL b2b_spacing gap%0d %0d cycles, required 10", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_random;
    rand_go = 1'b1;
    for (int k = 0; k < 40000 && rand_done < 6; k++) @(posedge clk);
    n_checks++;
    if (rand_done != 6) begin
      n_fails++;
      $display("FAIL rand_timeout configs done %0d, required 6", rand_done);
    end
  endtask

  initial begin
    void'($urandom(58897));
    u1.in_valid = 1'b0; u1.a = '0; u1.b = '0; u1.ci = 1'b0; u1.out_ready = 1'b0;
    u4.in_valid = 1'b0; u4.a = '0; u4.b = '0; u4.ci = 1'b0; u4.out_ready = 1'b0;
    test_reset;
    test_d1_basic;
    test_digit4;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
